// File: rtl/load_store_unit.sv
// load_store_unit: turns core load/store requests into word accesses on a
// 2^WORDS x 32 memory that samples on negedge. Sub-word stores use
// read-modify-write. Loads return the selected lane, sign or zero extended.

module load_store_unit #(
  parameter int WORDS      = 10,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  input  logic [31:0]           mem_data_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             we_q, we_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WORDS-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;

  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_val;
  logic [31:0]      merged;

  // Address bits above the memory window only wrap; they carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[ADDR_WIDTH-1:WORDS+2];

  // Size/alignment legality of a request; stores have no unsigned variants.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Lane extraction, extension and read-modify-write merge of the read word.
  always_comb begin
    lane_half = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (lane_q)
      2'd0:    lane_byte = mem_data_i[7:0];
      2'd1:    lane_byte = mem_data_i[15:8];
      2'd2:    lane_byte = mem_data_i[23:16];
      default: lane_byte = mem_data_i[31:24];
    endcase
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{~funct3_q[2] & lane_half[15]}}, lane_half};
      default: load_val = mem_data_i;
    endcase
    merged = mem_data_i;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and next-output logic; strobes default inactive so each lasts one cycle.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_rd_d   = 1'b1;
    mem_wr_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          lane_d     = addr_i[1:0];
          funct3_d   = funct3_i;
          we_d       = we_i;
          wdata_d    = wdata_i[15:0];
          mem_addr_d = addr_i[WORDS+1:2];
          err_d      = access_err(we_i, funct3_i, addr_i[1:0]);
          if (access_err(we_i, funct3_i, addr_i[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (we_i && (funct3_i == 3'b010)) begin
            state_d    = WR;
            mem_wr_d   = 1'b0;
            mem_data_d = wdata_i;
          end else begin
            state_d  = RD;
            mem_rd_d = 1'b0;
          end
        end
      end
      RD: begin
        state_d = DATA;
      end
      DATA: begin
        if (we_q) begin
          state_d    = WR;
          mem_wr_d   = 1'b0;
          mem_data_d = merged;
        end else begin
          state_d = DONE;
          rdata_d = load_val;
          done_d  = 1'b1;
        end
      end
      WR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset drops strobes immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      funct3_q   <= 3'd0;
      we_q       <= 1'b0;
      wdata_q    <= 16'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 32'd0;
      mem_rd_q   <= 1'b1;
      mem_wr_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_wr_o   = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors against a negedge memory
// model; expectations go into a scoreboard queue and are checked on done_o.

module tb_load_store_unit;

  logic        clk_i, reset_i, req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, rdata_o, mem_data_o, mem_data_i;
  logic        done_o, err_o, busy_o, mem_rd_o, mem_wr_o;
  logic [9:0]  mem_addr_o;

  load_store_unit #(.WORDS(10), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_data_i(mem_data_i)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          rd_n;
    int          wr_n;
    logic [9:0]  maddr;
    logic [31:0] wdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mem [1024];
  logic [31:0] mem_rdata;

  assign mem_data_i = mem_rdata;

  // Clock generation.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Cycle counter used to measure latency from the accepting edge.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: preload, then sample strobes on every negedge.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5]    = 32'h1111000B;
    mem[18]   = 32'hD0B0A090;
    mem[10]   = 32'h55AA3312;
    mem[20]   = 32'h01020304;
    mem[21]   = 32'h0A0B0C0D;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk_i);
      if (!mem_rd_o) mem_rdata <= mem[mem_addr_o];
      if (!mem_wr_o) mem[mem_addr_o] <= mem_data_o;
    end
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and checks the scoreboard head on each done_o.
  int          rd_n = 0, wr_n = 0;
  logic [9:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  always @(negedge clk_i) begin
    exp_t it;
    if (reset_i) begin
      rd_n = 0;
      wr_n = 0;
    end else begin
      checkOutput("strobe_excl", {31'd0, (!mem_rd_o && !mem_wr_o)}, 32'd0);
      if (!mem_rd_o) begin
        rd_n++;
        rd_addr = mem_addr_o;
      end
      if (!mem_wr_o) begin
        wr_n++;
        wr_addr = mem_addr_o;
        wr_data = mem_data_o;
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          checkOutput({it.name, "_rdata"}, rdata_o, it.rdata);
          checkOutput({it.name, "_err"}, {31'd0, err_o}, {31'd0, it.err});
          checkOutput({it.name, "_latency"}, cyc, it.due);
          checkOutput({it.name, "_rd_cnt"}, rd_n, it.rd_n);
          checkOutput({it.name, "_wr_cnt"}, wr_n, it.wr_n);
          if (rd_n > 0) checkOutput({it.name, "_rd_addr"}, {22'd0, rd_addr}, {22'd0, it.maddr});
          if (wr_n > 0) begin
            checkOutput({it.name, "_wr_addr"}, {22'd0, wr_addr}, {22'd0, it.maddr});
            checkOutput({it.name, "_wr_data"}, wr_data, it.wdata);
          end
          rd_n = 0;
          wr_n = 0;
        end
      end
    end
  end

  // Issue one request, push its expectation, wait (bounded) for return to IDLE.
  task automatic applyStimulus(input string name, input logic we,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_rd, input int exp_wr,
                               input logic [31:0] exp_wdata, input int lat, input bit hold);
    exp_t it;
    int   n;
    we_i     = we;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wdata;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1;
    it.name  = name;
    it.rdata = exp_rdata;
    it.err   = exp_err;
    it.rd_n  = exp_rd;
    it.wr_n  = exp_wr;
    it.maddr = addr[11:2];
    it.wdata = exp_wdata;
    it.due   = cyc + lat;
    sb.push_back(it);
    if (hold) begin
      n = 0;
      while (!done_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      checkOutput({name, "_hold_done"}, {31'd0, done_o}, 32'd1);
    end
    req_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({name, "_timeout"}, {31'd0, busy_o}, 32'd0);
    if (!hold) @(negedge clk_i);
  endtask

  initial begin
    reset_i  = 1'b1;
    req_i    = 1'b0;
    we_i     = 1'b0;
    funct3_i = 3'd0;
    addr_i   = 32'd0;
    wdata_i  = 32'd0;
    #2;
    checkOutput("rst_rdata", rdata_o, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_maddr", {22'd0, mem_addr_o}, 32'd0);
    checkOutput("rst_mdata", mem_data_o, 32'd0);
    checkOutput("rst_rd", {31'd0, mem_rd_o}, 32'd1);
    checkOutput("rst_wr", {31'd0, mem_wr_o}, 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    //            name     we  f3      addr    wdata         rdata         err rd wr wdata        lat hold
    applyStimulus("lw14",  0, 3'b010, 32'h14, 32'h0,        32'h1111000B, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("lb4b",  0, 3'b000, 32'h4B, 32'h0,        32'hFFFFFFD0, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("lbu4b", 0, 3'b100, 32'h4B, 32'h0,        32'h000000D0, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("lh4a",  0, 3'b001, 32'h4A, 32'h0,        32'hFFFFD0B0, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("lhu48", 0, 3'b101, 32'h48, 32'h0,        32'h0000A090, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("sb29",  1, 3'b000, 32'h29, 32'h000000EE, 32'h0000A090, 0, 1, 1, 32'h55AAEE12, 3, 0);
    applyStimulus("lw28",  0, 3'b010, 32'h28, 32'h0,        32'h55AAEE12, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("sw00",  1, 3'b010, 32'h00, 32'hDEADBEEF, 32'h55AAEE12, 0, 0, 1, 32'hDEADBEEF, 1, 0);
    applyStimulus("lw16",  0, 3'b010, 32'h16, 32'h0,        32'h55AAEE12, 1, 0, 0, 32'h0,        0, 0);
    applyStimulus("lh49",  0, 3'b001, 32'h49, 32'h0,        32'h55AAEE12, 1, 0, 0, 32'h0,        0, 0);
    applyStimulus("sh4b",  1, 3'b001, 32'h4B, 32'h1234,     32'h55AAEE12, 1, 0, 0, 32'h0,        0, 0);
    applyStimulus("f3011", 0, 3'b011, 32'h40, 32'h0,        32'h55AAEE12, 1, 0, 0, 32'h0,        0, 0);
    applyStimulus("sbu40", 1, 3'b100, 32'h40, 32'h0,        32'h55AAEE12, 1, 0, 0, 32'h0,        0, 0);
    applyStimulus("lbu00", 0, 3'b100, 32'h00, 32'h0,        32'h000000EF, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("sbhold",1, 3'b000, 32'h56, 32'h00000077, 32'h000000EF, 0, 1, 1, 32'h0A770C0D, 3, 1);
    repeat (4) @(negedge clk_i);
    checkOutput("hold_idle", {31'd0, busy_o}, 32'd0);
    applyStimulus("lw54",  0, 3'b010, 32'h54, 32'h0,        32'h0A770C0D, 0, 1, 0, 32'h0,        2, 0);
    applyStimulus("sh56",  1, 3'b001, 32'h56, 32'h0000BEEF, 32'h0A770C0D, 0, 1, 1, 32'hBEEF0C0D, 3, 0);
    applyStimulus("lh56",  0, 3'b001, 32'h56, 32'h0,        32'hFFFFBEEF, 0, 1, 0, 32'h0,        2, 0);

    // Reset while the sub-word store sits in WR: nothing may reach memory.
    we_i     = 1'b1;
    funct3_i = 3'b000;
    addr_i   = 32'h50;
    wdata_i  = 32'h000000AA;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checkOutput("rmw_in_wr", {31'd0, mem_wr_o}, 32'd0);
    reset_i = 1'b1;
    #1;
    checkOutput("rst_wr_rel", {31'd0, mem_wr_o}, 32'd1);
    checkOutput("rst_rd_rel", {31'd0, mem_rd_o}, 32'd1);
    checkOutput("rst_busy_mid", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_mem_kept", mem[20], 32'h01020304);
    checkOutput("rst_no_done", {31'd0, done_o}, 32'd0);
    applyStimulus("lw50",  0, 3'b010, 32'h50, 32'h0,        32'h01020304, 0, 1, 0, 32'h0,        2, 0);

    repeat (3) @(negedge clk_i);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator that turns core load/store requests into word-wide accesses on the 1024x32 BRAM memory. It handles byte, halfword and word accesses, including sign/zero extension on loads. Sub-word stores use read-modify-write. It drives the memory's active-low read/write strobes and word address, sits between the multicycle control/datapath and the memory block, and reports completion with a one-cycle `done_o`.

## Interface
Parameters:
- `WORDS`, 10: memory word-address width (2^WORDS words).
- `ADDR_WIDTH`, 32: byte-address width from the core.

Ports:
- `clk_i` in 1: clock. The block is posedge; the memory samples on negedge.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_i` in 1: request strobe. Sampled only in IDLE.
- `we_i` in 1: 1 = store, 0 = load.
- `funct3_i` in 3: RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_i` in ADDR_WIDTH: byte address.
- `wdata_i` in 32: store data, right-aligned.
- `rdata_o` out 32: load result, extended.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: misaligned access or illegal funct3. Valid while `done_o` is high.
- `busy_o` out 1: high when the state is not IDLE.
- `mem_addr_o` out WORDS: word address to memory.
- `mem_data_o` out 32: write data to memory.
- `mem_rd_o` out 1: memory read enable, active low.
- `mem_wr_o` out 1: memory write enable, active low.
- `mem_data_i` in 32: memory read data.

## Operation
- States: IDLE, RD, DATA, WR, DONE.
- On `req_i` in IDLE, latch `addr_i`, `funct3_i`, `we_i` and `wdata_i`.
- `mem_addr_o` = latched `addr[WORDS+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(WORDS+2).
- Lanes are little-endian: byte lane = `addr[1:0]`, byte 0 = bits 7:0; halfword lane = `addr[1]`.
- Error check:
  - H/HU with `addr[0]`=1 is an error.
  - W with `addr[1:0]`≠0 is an error.
  - funct3 011, 110 and 111 are errors.
  - Store with funct3[2]=1 is an error.
  - On error: IDLE→DONE, `err_o`=1, no memory strobe, `rdata_o` unchanged.
- Loads: IDLE→RD→DATA→DONE.
  - RD: `mem_rd_o`=0 for exactly one cycle.
  - DATA: capture `mem_data_i`, extract the lane, extend (sign for B/H, zero for BU/HU), register the result into `rdata_o`.
- Word store: IDLE→WR→DONE. `mem_data_o`=`wdata_i` and `mem_wr_o`=0 for exactly one cycle. No read is issued.
- Sub-word store: IDLE→RD→DATA→WR→DONE.
  - In DATA, merge the read word: replace the selected byte with `wdata_i[7:0]`, or the selected halfword with `wdata_i[15:0]`.
  - The merged word goes to `mem_data_o` during WR.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- `err_o` holds until the next accepted request.
- `req_i` outside IDLE is ignored (not queued).
- `rdata_o` holds its value until the next successful load. Stores never change it.
- `mem_rd_o` and `mem_wr_o` are never low in the same cycle.

## Timing
- Strobes, address and write data are registered at posedge. The memory samples them at the following negedge (half-cycle path).
- Memory read data updates at the negedge inside RD and is consumed at the posedge that leaves DATA.
- Latency is counted from the accepting edge E0:
  - Load: `done_o` high in the cycle after E0+2.
  - Sub-word store: `done_o` high in the cycle after E0+3.
  - Word store: `done_o` high in the cycle after E0+1.
  - Error: `done_o` high in the cycle after E0.
- Back-to-back: a new `req_i` can be accepted at the edge that leaves DONE+1, i.e. the first cycle back in IDLE.
- Reset values: state IDLE; `rdata_o`=0, `done_o`=0, `err_o`=0, `busy_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `mem_rd_o`=1, `mem_wr_o`=1.
- Reset asserted mid-operation (including in WR) deasserts both strobes immediately, asynchronously, before the next negedge. The interrupted store is abandoned and no `done_o` is issued.

## Test plan
- LW at 0x14 with mem[5]=0x1111000B → `mem_rd_o` low exactly 1 cycle with `mem_addr_o`=5, `done_o` after E0+2, `rdata_o`=0x1111000B, `err_o`=0, no write strobe.
- Word 18=0xD0B0A090:
  - LB 0x4B → 0xFFFFFFD0
  - LBU 0x4B → 0x000000D0
  - LH 0x4A → 0xFFFFD0B0
  - LHU 0x48 → 0x0000A090
- SB 0x29 with `wdata_i`=0x000000EE on word 10=0x55AA3312 → one read, then one write with `mem_data_o`=0x55AAEE12; `done_o` after E0+3. A following LW 0x28 returns 0x55AAEE12.
- SW 0x00 with 0xDEADBEEF → `mem_rd_o` never low, `mem_wr_o` low 1 cycle with `mem_addr_o`=0; `done_o` after E0+1.
- Misaligned and illegal requests (LW 0x16, LH 0x49, SH 0x4B, funct3 011, SBU) → no strobes, `done_o` after E0, `err_o`=1, `rdata_o` unchanged.
- Busy and reset behaviour:
  - `req_i` held high during a busy SB → only one transaction completes.
  - `reset_i` pulsed while in WR → `mem_wr_o` returns to 1 within the reset cycle, memory word unchanged, `busy_o`=0, `done_o` not asserted.
